// File: rtl/trigger_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trigger_seq_pkg
// Description : Shared state encoding, default widths and helpers for the
//               trigger sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package trigger_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    localparam int         DEF_CNT_W      = 16;
    localparam int         DEF_DLY_W      = 32;
    localparam int         DEF_PW_W       = 16;
    localparam logic [7:0] C_FIRE_CNT_MAX = 8'd255;

    function automatic logic [7:0] fire_sat_inc(input logic [7:0] value);
        return (value == C_FIRE_CNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : trigger_sequencer_if
// Description : Control, configuration and status bundle of the trigger
//               sequencer. master = controller side, slave = sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface trigger_sequencer_if #(
    parameter int CNT_W = trigger_seq_pkg::DEF_CNT_W,
    parameter int DLY_W = trigger_seq_pkg::DEF_DLY_W,
    parameter int PW_W  = trigger_seq_pkg::DEF_PW_W
);
    logic             arm;
    logic             abort;
    logic             auto_rearm;
    logic [CNT_W-1:0] edge_target;
    logic [DLY_W-1:0] delay_cycles;
    logic [PW_W-1:0]  pulse_width;
    logic             trigger_in;
    logic             glitch_out;
    logic             armed;
    logic             busy;
    logic             done;
    logic [2:0]       state;
    logic [7:0]       fire_count;

    modport master (
        output arm, abort, auto_rearm, edge_target, delay_cycles, pulse_width, trigger_in,
        input  glitch_out, armed, busy, done, state, fire_count
    );

    modport slave (
        input  arm, abort, auto_rearm, edge_target, delay_cycles, pulse_width, trigger_in,
        output glitch_out, armed, busy, done, state, fire_count
    );
endinterface
`default_nettype wire

// File: rtl/seq_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_down_counter
// Description : Loadable down counter that parks at 1 and flags expiry there.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_down_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic             enable,
    input  wire logic [WIDTH-1:0] load_value,
    output logic      [WIDTH-1:0] value,
    output logic                  expire
);
    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_value;
        end else if (enable && (r_value > C_ONE)) begin
            r_value <= r_value - C_ONE;
        end
    end

    assign value  = r_value;
    assign expire = (r_value == C_ONE);
endmodule
`default_nettype wire

// File: rtl/trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trigger_sequencer
// Description : Counts N qualified trigger events, waits a programmable delay
//               and emits one fire pulse of programmable width.
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_sequencer
    import trigger_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DLY_W = DEF_DLY_W,
    parameter int PW_W  = DEF_PW_W
) (
    input  wire logic           sampleclk,
    input  wire logic           reset,
    trigger_sequencer_if.slave  bus
);
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PW_W-1:0]  C_PW_ONE  = {{(PW_W-1){1'b0}}, 1'b1};

    seq_state_t       r_state, w_next;
    logic [CNT_W-1:0] r_tgt, r_edge_cnt, w_edge_inc;
    logic [DLY_W-1:0] r_dly, w_dly_val;
    logic [PW_W-1:0]  r_pw, w_pw_val;
    logic             w_latch, w_edge_en;
    logic             w_dly_load, w_dly_en, w_dly_exp;
    logic             w_pw_load, w_pw_en, w_pw_exp;
    logic             w_fire;
    logic             r_glitch;
    logic [7:0]       r_fire_cnt;

    assign w_edge_inc = r_edge_cnt + C_CNT_ONE;

    always_ff @(posedge sampleclk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_edge_en  = 1'b0;
        w_dly_load = 1'b0;
        w_dly_en   = 1'b0;
        w_pw_load  = 1'b0;
        w_pw_en    = 1'b0;
        w_fire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.arm && !bus.abort) begin
                    w_latch = 1'b1;
                    w_next  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bus.abort) begin
                    w_next = ST_IDLE;
                end else if (bus.trigger_in) begin
                    w_edge_en = 1'b1;
                    if (w_edge_inc == r_tgt) begin
                        if (r_dly == '0) begin
                            w_pw_load = 1'b1;
                            w_next    = ST_PULSE;
                        end else begin
                            w_dly_load = 1'b1;
                            w_next     = ST_DELAY;
                        end
                    end
                end
            end
            ST_DELAY: begin
                if (bus.abort) begin
                    w_next = ST_IDLE;
                end else if (w_dly_exp) begin
                    w_pw_load = 1'b1;
                    w_next    = ST_PULSE;
                end else begin
                    w_dly_en = 1'b1;
                end
            end
            ST_PULSE: begin
                if (bus.abort) begin
                    w_next = ST_IDLE;
                end else if (w_pw_exp) begin
                    w_fire = 1'b1;
                    w_next = ST_DONE;
                end else begin
                    w_pw_en = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.abort) begin
                    w_next = ST_IDLE;
                end else if (bus.auto_rearm) begin
                    w_latch = 1'b1;
                    w_next  = ST_ARMED;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Shadow config: a zero target or width is stored as one at latch time.
    always_ff @(posedge sampleclk) begin
        if (reset) begin
            r_tgt      <= '0;
            r_dly      <= '0;
            r_pw       <= '0;
            r_edge_cnt <= '0;
        end else if (w_latch) begin
            r_tgt      <= (bus.edge_target == '0) ? C_CNT_ONE : bus.edge_target;
            r_dly      <= bus.delay_cycles;
            r_pw       <= (bus.pulse_width == '0) ? C_PW_ONE : bus.pulse_width;
            r_edge_cnt <= '0;
        end else if (w_edge_en) begin
            r_edge_cnt <= w_edge_inc;
        end
    end

    always_ff @(posedge sampleclk) begin
        if (reset) begin
            r_glitch   <= 1'b0;
            r_fire_cnt <= 8'd0;
        end else begin
            r_glitch <= (w_next == ST_PULSE);
            if (w_fire) begin
                r_fire_cnt <= fire_sat_inc(r_fire_cnt);
            end
        end
    end

    seq_down_counter #(.WIDTH(DLY_W)) u_dly_cnt (
        .clk        (sampleclk),
        .rst        (reset),
        .load       (w_dly_load),
        .enable     (w_dly_en),
        .load_value (r_dly),
        .value      (w_dly_val),
        .expire     (w_dly_exp)
    );

    seq_down_counter #(.WIDTH(PW_W)) u_pw_cnt (
        .clk        (sampleclk),
        .rst        (reset),
        .load       (w_pw_load),
        .enable     (w_pw_en),
        .load_value (r_pw),
        .value      (w_pw_val),
        .expire     (w_pw_exp)
    );

    assign bus.glitch_out = r_glitch;
    assign bus.armed      = (r_state == ST_ARMED);
    assign bus.busy       = (r_state == ST_ARMED) || (r_state == ST_DELAY) || (r_state == ST_PULSE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.state      = r_state;
    assign bus.fire_count = r_fire_cnt;

    // Counter values are only needed for expiry; keep them observable for debug.
    logic w_unused;
    assign w_unused = ^{w_dly_val, w_pw_val};
endmodule
`default_nettype wire

// File: tb/tb_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trigger_sequencer
// Description : Directed bench with a timeline model of the trigger sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_sequencer;
    localparam int CNT_W = 16;
    localparam int DLY_W = 32;
    localparam int PW_W  = 16;

    logic sampleclk = 1'b0;
    logic reset     = 1'b1;
    int   n_cmp     = 0;
    int   n_err     = 0;
    bit   chk_en    = 1'b0;

    trigger_sequencer_if #(.CNT_W(CNT_W), .DLY_W(DLY_W), .PW_W(PW_W)) bus ();

    trigger_sequencer #(.CNT_W(CNT_W), .DLY_W(DLY_W), .PW_W(PW_W)) dut (
        .sampleclk (sampleclk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 sampleclk = ~sampleclk;

    // Timeline model: once the qualifying event is seen, the pulse window and
    // the done cycle are fixed absolute cycle numbers.
    longint cyc = 0;
    int     m_mode = 0;            // 0 idle, 1 counting events, 2 timeline running
    longint m_tgt = 0, m_dly = 0, m_pw = 0, m_cnt = 0, m_start = 0;
    int     m_fires = 0;

    task automatic latch_model();
        m_tgt  = (bus.edge_target == 0) ? 1 : longint'(bus.edge_target);
        m_dly  = longint'(bus.delay_cycles);
        m_pw   = (bus.pulse_width == 0) ? 1 : longint'(bus.pulse_width);
        m_cnt  = 0;
        m_mode = 1;
    endtask

    always @(posedge sampleclk) begin
        cyc++;
        if (reset) begin
            m_mode  = 0;
            m_fires = 0;
        end else if (m_mode == 0) begin
            if (bus.arm && !bus.abort) latch_model();
        end else if (bus.abort) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (bus.trigger_in) begin
                m_cnt++;
                if (m_cnt == m_tgt) begin
                    m_start = cyc + m_dly;
                    m_mode  = 2;
                end
            end
        end else begin
            if (cyc == m_start + m_pw) begin
                m_fires = (m_fires < 255) ? m_fires + 1 : 255;
            end else if (cyc == m_start + m_pw + 1) begin
                if (bus.auto_rearm) latch_model();
                else m_mode = 0;
            end
        end
    end

    // {glitch_out, done, armed, busy, state, fire_count}
    function automatic logic [14:0] model_out();
        logic       g, d, a, b;
        logic [2:0] s;
        g = 1'b0; d = 1'b0; a = 1'b0; b = 1'b0; s = 3'd0;
        if (m_mode == 1) begin
            a = 1'b1; b = 1'b1; s = 3'd1;
        end else if (m_mode == 2) begin
            if (cyc < m_start) begin
                b = 1'b1; s = 3'd2;
            end else if (cyc < m_start + m_pw) begin
                b = 1'b1; g = 1'b1; s = 3'd3;
            end else begin
                d = 1'b1; s = 3'd4;
            end
        end
        return {g, d, a, b, s, 8'(m_fires)};
    endfunction

    always @(negedge sampleclk) begin
        logic [14:0] exp_v, act_v;
        if (chk_en) begin
            exp_v = model_out();
            act_v = {bus.glitch_out, bus.done, bus.armed, bus.busy, bus.state, bus.fire_count};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL model_cycle cyc=%0d actual=%h expected=%h", cyc, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge sampleclk);
        #1;
    endtask

    task automatic config_set(input int tgt, input int dly, input int pw, input bit ar);
        bus.edge_target  = CNT_W'(tgt);
        bus.delay_cycles = DLY_W'(dly);
        bus.pulse_width  = PW_W'(pw);
        bus.auto_rearm   = ar;
    endtask

    task automatic do_arm();
        bus.arm = 1'b1; step(); bus.arm = 1'b0;
    endtask

    task automatic pulse_trigger();
        bus.trigger_in = 1'b1; step(); bus.trigger_in = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget && !bus.done; i++) step();
        check("wait_done", 32'(bus.done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.arm = 0; bus.abort = 0; bus.trigger_in = 0;
        config_set(1, 0, 1, 1'b0);
        step();
        chk_en = 1'b1;
        step(2);
        reset = 1'b0;
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_fire", 32'(bus.fire_count), 32'd0);

        // 1: single event, no delay, one-cycle pulse
        do_arm();
        check("t1_armed", 32'(bus.armed), 32'd1);
        pulse_trigger();
        check("t1_glitch_t1", 32'(bus.glitch_out), 32'd1);
        step();
        check("t1_glitch_t2", 32'(bus.glitch_out), 32'd0);
        check("t1_done_t2", 32'(bus.done), 32'd1);
        check("t1_fire", 32'(bus.fire_count), 32'd1);
        step();
        check("t1_idle_t3", 32'(bus.state), 32'd0);

        // 2: three events, delay 10, width 4, a stray event during DELAY
        config_set(3, 10, 4, 1'b0);
        do_arm();
        for (int i = 0; i < 3; i++) begin
            pulse_trigger();
            if (i < 2) step(2);
        end
        check("t2_delay_state", 32'(bus.state), 32'd2);
        step(2);
        pulse_trigger();
        step(6);
        check("t2_glitch_t10", 32'(bus.glitch_out), 32'd0);
        step();
        check("t2_glitch_t11", 32'(bus.glitch_out), 32'd1);
        step(3);
        check("t2_glitch_t14", 32'(bus.glitch_out), 32'd1);
        step();
        check("t2_done_t15", 32'(bus.done), 32'd1);
        check("t2_fire", 32'(bus.fire_count), 32'd2);
        step();

        // 3: zero target and width behave as one
        config_set(0, 0, 0, 1'b0);
        do_arm();
        pulse_trigger();
        check("t3_glitch", 32'(bus.glitch_out), 32'd1);
        step();
        check("t3_done", 32'(bus.done), 32'd1);
        check("t3_fire", 32'(bus.fire_count), 32'd3);
        step();

        // 4: auto re-arm picks up a delay changed during PULSE
        config_set(1, 2, 3, 1'b1);
        do_arm();
        pulse_trigger();
        step(2);
        check("t4_glitch_start", 32'(bus.glitch_out), 32'd1);
        bus.delay_cycles = 32'd5;
        step(3);
        check("t4_done", 32'(bus.done), 32'd1);
        step();
        check("t4_rearmed", 32'(bus.armed), 32'd1);
        pulse_trigger();
        step(4);
        check("t4_new_delay_held", 32'(bus.state), 32'd2);
        step();
        check("t4_new_delay_fire", 32'(bus.glitch_out), 32'd1);
        bus.auto_rearm = 1'b0;
        wait_done(20);
        step();
        check("t4_idle", 32'(bus.state), 32'd0);
        check("t4_fire", 32'(bus.fire_count), 32'd5);

        // 5: abort in the fifth PULSE cycle
        config_set(1, 0, 20, 1'b0);
        do_arm();
        pulse_trigger();
        step(4);
        check("t5_in_pulse", 32'(bus.glitch_out), 32'd1);
        bus.abort = 1'b1; step(); bus.abort = 1'b0;
        check("t5_glitch_low", 32'(bus.glitch_out), 32'd0);
        check("t5_state_idle", 32'(bus.state), 32'd0);
        step(3);
        check("t5_fire_held", 32'(bus.fire_count), 32'd5);

        // 6: arm and abort together
        bus.arm = 1'b1; bus.abort = 1'b1; step(); bus.arm = 1'b0; bus.abort = 1'b0;
        check("t6_stay_idle", 32'(bus.state), 32'd0);

        // 7: reset during DELAY, later events ignored
        config_set(1, 50, 2, 1'b0);
        do_arm();
        pulse_trigger();
        step(3);
        check("t7_in_delay", 32'(bus.state), 32'd2);
        reset = 1'b1; step(); reset = 1'b0;
        check("t7_outputs_zero", 32'({bus.glitch_out, bus.done, bus.armed, bus.busy, bus.state, bus.fire_count}), 32'd0);
        pulse_trigger();
        step();
        check("t7_trigger_ignored", 32'(bus.state), 32'd0);

        // 8: continuous auto re-arm saturates fire_count
        config_set(1, 0, 1, 1'b1);
        bus.trigger_in = 1'b1;
        do_arm();
        step(600);
        check("t8_fire_200", 32'(bus.fire_count), 32'd200);
        step(300);
        check("t8_fire_sat", 32'(bus.fire_count), 32'd255);
        step(30);
        check("t8_fire_hold", 32'(bus.fire_count), 32'd255);
        bus.trigger_in = 1'b0;
        bus.auto_rearm = 1'b0;
        bus.abort = 1'b1; step(); bus.abort = 1'b0;
        step();
        check("t8_abort_idle", 32'(bus.state), 32'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
